// File: rtl/traffic_light_sequencer.sv
// Phase scheduler: sequences RED -> GREEN -> YELLOW -> RED on 1 Hz ticks, shortens GREEN for
// pedestrian requests and latches a fault mode that drops the controller enable.
module traffic_light_sequencer #(
    parameter int RED_TIME    = 10,
    parameter int GREEN_TIME  = 7,
    parameter int YELLOW_TIME = 3,
    parameter int PED_GREEN   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_ped_req,
    input  logic       i_fault,
    input  logic       i_clear,
    output logic [1:0] o_state,
    output logic       o_en,
    output logic [6:0] o_remaining,
    output logic       o_ped_ack,
    output logic       o_fault
);

    typedef enum logic [2:0] {S_IDLE, S_RED, S_GREEN, S_YELLOW, S_FAULT} state_t;

    localparam logic [6:0] RED_T    = 7'(RED_TIME);
    localparam logic [6:0] GREEN_T  = 7'(GREEN_TIME);
    localparam logic [6:0] YELLOW_T = 7'(YELLOW_TIME);
    localparam logic [6:0] PED_T    = 7'(PED_GREEN);

    state_t     state, state_n;
    logic [6:0] count, count_n;
    logic       ped_pending, ped_n, ped_eff, ack_n;

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            S_RED:    return 2'b01;
            S_GREEN:  return 2'b11;
            S_YELLOW: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

    // A request arriving this cycle counts as pending for truncation and RED-entry ack.
    assign ped_eff = ped_pending | (i_ped_req & ((state == S_GREEN) | (state == S_YELLOW)));

    always_comb begin
        state_n = state;
        count_n = count;
        ped_n   = ped_pending;
        ack_n   = 1'b0;
        if (i_fault) begin
            state_n = S_FAULT;
            count_n = '0;
            ped_n   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        state_n = S_RED;
                        count_n = RED_T;
                    end
                end
                S_FAULT: begin
                    if (i_clear) state_n = S_IDLE;
                end
                default: begin
                    if (!i_run) begin
                        state_n = S_IDLE;
                        count_n = '0;
                        ped_n   = 1'b0;
                    end else if (i_tick && count == 7'd1) begin
                        ped_n = ped_eff;
                        case (state)
                            S_RED: begin
                                state_n = S_GREEN;
                                count_n = GREEN_T;
                            end
                            S_GREEN: begin
                                state_n = S_YELLOW;
                                count_n = YELLOW_T;
                            end
                            default: begin
                                state_n = S_RED;
                                count_n = RED_T;
                                ack_n   = ped_eff;
                                ped_n   = 1'b0;
                            end
                        endcase
                    end else if (state == S_GREEN && ped_eff && count > PED_T) begin
                        // count > PED_GREEN implies count-1 >= PED_GREEN, so a coincident tick still lands here
                        count_n = PED_T;
                        ped_n   = 1'b1;
                    end else begin
                        ped_n = ped_eff;
                        if (i_tick) count_n = count - 7'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            ped_pending <= 1'b0;
            o_state     <= 2'b00;
            o_en        <= 1'b0;
            o_ped_ack   <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            ped_pending <= ped_n;
            o_state     <= state_code(state_n);
            o_en        <= (state_n == S_RED) || (state_n == S_GREEN) || (state_n == S_YELLOW);
            o_ped_ack   <= ack_n;
            o_fault     <= (state_n == S_FAULT);
        end
    end

    assign o_remaining = count;

endmodule
